player_keys: RTL and testbench

Keyboard front end for the player ship. It consumes the byte stream from the PS/2 receiver (scan-code set 2) and tracks make/break sequences, including the E0 extended prefix and the F0 break prefix. It produces the held-level movement commands (move_left, move_right, move_up, move_down) that drive the player movement block, plus shoot and pause controls. It sits between the PS/2 byte receiver and player_move/player_shot in the top level.

---
 rtl/player_keys_if.sv | 8 +
 rtl/player_keys.sv | 121 ++++++++++++
 tb/tb_player_keys.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/player_keys_if.sv
// Byte stream from the PS/2 receiver into the keyboard front end.
interface player_keys_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/player_keys.sv
// Scan-code set 2 decoder: tracks E0/F0 prefixes and turns make/break
// sequences into held movement levels plus shoot/pause controls.
//
// state   | meaning
// IDLE    | no prefix pending
// EXT     | E0 seen
// BRK     | F0 seen
// EXT_BRK | E0 F0 seen
module player_keys #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] KEY_LEFT       = 8'h6B,
    parameter logic [7:0] KEY_RIGHT      = 8'h74,
    parameter logic [7:0] KEY_UP         = 8'h75,
    parameter logic [7:0] KEY_DOWN       = 8'h72,
    parameter logic [7:0] KEY_SHOOT      = 8'h29,
    parameter logic [7:0] KEY_PAUSE      = 8'h4D
) (
    input  logic              clk,
    input  logic              resetN,
    player_keys_if.slave      rx,
    output logic              move_left,
    output logic              move_right,
    output logic              move_up,
    output logic              move_down,
    output logic              shoot,
    output logic              shoot_pulse,
    output logic              pause_toggle
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 18) ? $clog2(TIMEOUT_CYCLES) : 18;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             pause_held;
    logic             ev_make, ev_brk, ev_ext;

    always_comb begin
        state_nxt = state;
        ev_make   = 1'b0;
        ev_brk    = 1'b0;
        ev_ext    = 1'b0;
        if (rx.rx_valid) begin
            unique case (state)
                IDLE: begin
                    if (rx.rx_data == CODE_EXT)      state_nxt = EXT;
                    else if (rx.rx_data == CODE_BRK) state_nxt = BRK;
                    else                             ev_make   = 1'b1;
                end
                EXT: begin
                    if (rx.rx_data == CODE_BRK) state_nxt = EXT_BRK;
                    else if (rx.rx_data != CODE_EXT) begin
                        ev_make   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    if (rx.rx_data != CODE_BRK) begin
                        ev_brk    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (rx.rx_data != CODE_EXT && rx.rx_data != CODE_BRK) begin
                        ev_brk    = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && cnt == CNT_TOP) begin
            // abandoned partial sequence: drop back without touching key state
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            cnt          <= '0;
            move_left    <= 1'b0;
            move_right   <= 1'b0;
            move_up      <= 1'b0;
            move_down    <= 1'b0;
            shoot        <= 1'b0;
            shoot_pulse  <= 1'b0;
            pause_held   <= 1'b0;
            pause_toggle <= 1'b0;
        end else begin
            state        <= state_nxt;
            shoot_pulse  <= 1'b0;
            pause_toggle <= 1'b0;

            if (rx.rx_valid || state_nxt == IDLE) cnt <= '0;
            else                                  cnt <= cnt + 1'b1;

            if (ev_make || ev_brk) begin
                // arrows accept both plain and E0 forms so the numpad works too
                if (rx.rx_data == KEY_LEFT)  move_left  <= ev_make;
                if (rx.rx_data == KEY_RIGHT) move_right <= ev_make;
                if (rx.rx_data == KEY_UP)    move_up    <= ev_make;
                if (rx.rx_data == KEY_DOWN)  move_down  <= ev_make;
                if (!ev_ext && rx.rx_data == KEY_SHOOT) begin
                    shoot       <= ev_make;
                    shoot_pulse <= ev_make && !shoot;
                end
                if (!ev_ext && rx.rx_data == KEY_PAUSE) begin
                    pause_held   <= ev_make;
                    pause_toggle <= ev_make && !pause_held;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_keys.sv
// Scoreboard bench for player_keys: a behavioural key model pushes the
// expected output vector per cycle, popped and compared after the edge.
module tb_player_keys;

    localparam int TO = 20;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic move_left, move_right, move_up, move_down, shoot, shoot_pulse, pause_toggle;

    player_keys_if rx_if ();

    player_keys #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .rx           (rx_if.slave),
        .move_left    (move_left),
        .move_right   (move_right),
        .move_up      (move_up),
        .move_down    (move_down),
        .shoot        (shoot),
        .shoot_pulse  (shoot_pulse),
        .pause_toggle (pause_toggle)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pulse_cnt = 0;

    logic [6:0] exp_q[$];
    wire  [6:0] obs = {move_left, move_right, move_up, move_down, shoot, shoot_pulse, pause_toggle};

    // reference model: pending-prefix flags instead of a state encoding
    bit m_l, m_r, m_u, m_d, m_s, m_sp, m_pt, m_ph;
    bit pend_ext, pend_brk;
    int idle_run;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b (L R U D S SP PT) at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        {m_l, m_r, m_u, m_d, m_s, m_sp, m_pt, m_ph} = '0;
        pend_ext = 0; pend_brk = 0; idle_run = 0;
    endtask

    task automatic model_key(input bit make, input bit ext, input logic [7:0] code);
        case (code)
            8'h6B: m_l = make;
            8'h74: m_r = make;
            8'h75: m_u = make;
            8'h72: m_d = make;
            8'h29: if (!ext) begin m_sp = make && !m_s; m_s = make; end
            8'h4D: if (!ext) begin m_pt = make && !m_ph; m_ph = make; end
            default: ;
        endcase
    endtask

    task automatic model_step(input bit v, input logic [7:0] d);
        m_sp = 0; m_pt = 0;
        if (v) begin
            idle_run = 0;
            if (d == 8'hF0) pend_brk = 1;
            else if (d == 8'hE0 && !pend_brk) pend_ext = 1;
            else if (d == 8'hE0 && pend_brk && pend_ext) ;
            else begin
                model_key(!pend_brk, pend_ext, d);
                pend_ext = 0; pend_brk = 0;
            end
        end else if (pend_ext || pend_brk) begin
            idle_run++;
            if (idle_run == TO) begin pend_ext = 0; pend_brk = 0; idle_run = 0; end
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input string tag);
        logic [6:0] want;
        model_step(v, d);
        exp_q.push_back({m_l, m_r, m_u, m_d, m_s, m_sp, m_pt});
        rx_if.rx_valid = v;
        rx_if.rx_data  = v ? d : $urandom_range(0, 255);
        @(posedge clk);
        #1;
        rx_if.rx_valid = 1'b0;
        want = exp_q.pop_front();
        if (shoot_pulse) pulse_cnt++;
        chk(tag, obs, want);
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b1, d, $sformatf("byte_%h", d));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, "idle");
    endtask

    initial begin
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", obs, 7'b0);
        resetN = 1'b1;
        idle(2);

        // extended left make/break
        send(8'hE0); send(8'h6B);
        chk("ext_left_make", obs, 7'b1000000);
        idle(3);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("ext_left_break", obs, 7'b0);
        idle(2);

        // shoot typematic, break, fresh press
        pulse_cnt = 0;
        send(8'h29); send(8'h29); send(8'h29);
        chk("one_pulse_typematic", {6'b0, pulse_cnt == 1}, 7'b1);
        send(8'hF0); send(8'h29);
        send(8'h29);
        chk("second_pulse", {6'b0, pulse_cnt == 2}, 7'b1);
        send(8'hF0); send(8'h29);

        // stale prefixes expire after TO idle cycles
        send(8'hE0); idle(TO); send(8'h74);
        chk("stale_ext_right", obs, 7'b0100000);
        send(8'hF0); idle(TO); send(8'h74);
        chk("stale_brk_keeps_right", obs, 7'b0100000);
        // byte lands on the expiry cycle: still decoded as a break
        send(8'hF0); idle(TO - 1); send(8'h74);
        chk("byte_wins_expiry", obs, 7'b0);

        // back-to-back up/down, then non-extended break of up
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
        chk("up_down_both", obs, 7'b0011000);
        send(8'hF0); send(8'h75);
        chk("up_cleared_only", obs, 7'b0001000);
        send(8'hF0); send(8'h72);

        // ignored codes leave the FSM in IDLE
        send(8'hE0); send(8'h29); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h4D);
        send(8'h4D);
        chk("pause_after_ignored", obs, 7'b0000001);
        send(8'hF0); send(8'h4D);

        // asynchronous reset mid-sequence
        send(8'h6B); send(8'h29); send(8'hE0);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_reset_clears", obs, 7'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        resetN = 1'b1;
        send(8'h6B);
        chk("left_after_reset", obs, 7'b1000000);
        send(8'hF0); send(8'h6B);

        // random mix of mapped codes and prefixes with occasional gaps
        for (int i = 0; i < 300; i++) begin
            logic [7:0] pool [10];
            pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h4D, 8'h1C, 8'hE0};
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, TO + 2));
            else send(pool[$urandom_range(0, 9)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
